serial_subtractor: RTL

Parametrised bit-serial N-bit subtractor with borrow-in. It processes operands LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow. It is the sequential, multi-bit successor to the combinational half subtractor. It uses a start/busy/done handshake and reports difference, borrow-out, zero and signed-overflow flags.

---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit
// per clock through a single full-subtractor cell with a registered borrow.
// A start/busy/done handshake frames each operation. Results (diff, bout,
// zero, ovf) are held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_bit;
  logic             cell_d;
  logic             cell_b;
  logic [WIDTH-1:0] sd_next;

  // A start is honoured only when no operation is in flight.
  assign accept   = start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs and the registered borrow.
  assign cell_d  = sa_q[0] ^ sb_q[0] ^ br_q;
  assign cell_b  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sd_next = {cell_d, sd_q[WIDTH-1:1]};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE/DONE accept start, RUN ends on the last bit.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake decoded from state, results from holding regs.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
    zero = zero_q;
    ovf  = ovf_q;
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, load results last.
  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (accept) begin
      sa_d    = a;
      sb_d    = b;
      br_d    = bin;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (state_q == RUN) begin
      sa_d  = {1'b0, sa_q[WIDTH-1:1]};
      sb_d  = {1'b0, sb_q[WIDTH-1:1]};
      sd_d  = sd_next;
      br_d  = cell_b;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_d = sd_next;
        bout_d = cell_b;
        zero_d = (sd_next == '0);
        // Signed overflow: operand signs differ and result sign leaves a's sign.
        ovf_d  = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
      end
    end
  end

  // Datapath registers.
  // NOTE: every register, including the shift registers, is reset so an abort
  // leaves no stale operand or result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
